// File: rtl/piso_2of4_tx.sv
// piso_2of4_tx
// Parallel-in serial-out transmitter for the 2-of-4 gated serial link.
// A word accepted over the valid/ready handshake is sent MSB first, one bit
// per cycle. Bits only go out in phases 0 and 1 of each free-running
// 4-cycle frame; phases 2 and 3 are always idle on the line.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        parallel word to transmit (N_BIT wide)
//   din_valid  din holds a word to send
//   din_ready  block can accept a word this cycle
//   sout       serial data, MSB first, 0 when sout_valid is low
//   sout_valid sout carries a data bit this cycle
//   phase      free-running frame phase 0..3
//   busy       a word is currently held
//   done       one-cycle pulse after the last bit has gone out
module piso_2of4_tx #(
    parameter int N_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BIT-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done
);

    // Wide enough to hold the value N_BIT itself
    localparam int CW = $clog2(N_BIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t           state;
    logic [N_BIT-1:0] shreg;
    logic [CW-1:0]    bitcnt;
    logic             shift_now;

    // A bit is on the line only while sending and in the first half of the frame
    assign shift_now  = (state == SEND) && !phase[1];

    // Outputs derived directly from the state, the frame phase and the MSB
    assign din_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign sout_valid = shift_now;
    assign sout       = shift_now & shreg[N_BIT-1];

    // Frame counter, transmit FSM and shift register. The phase counter
    // runs regardless of the FSM so sender and receiver stay frame-aligned.
    // ARMED waits for the phase-3 edge so that the first bit always lands
    // on phase 0; a word loaded on a phase-3 edge therefore waits a full
    // frame. The word ends on the edge that consumes its last bit, which
    // for odd widths happens at phase 0 and leaves phase 1 idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= 2'd0;
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            done   <= 1'b0;
        end else begin
            phase <= phase + 2'd1;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        shreg  <= din;
                        bitcnt <= CW'(N_BIT);
                        state  <= ARMED;
                    end
                end
                ARMED: begin
                    if (phase == 2'd3) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (shift_now) begin
                        shreg  <= shreg << 1;
                        bitcnt <= bitcnt - CW'(1);
                        if (bitcnt == CW'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_2of4_tx.sv
// tb_piso_2of4_tx
// Self-checking bench for piso_2of4_tx. One instance uses N_BIT=4 and a
// second uses N_BIT=3 for the odd-width case; both share clock and reset.
// Every accepted word pushes its bits onto a per-instance queue and a
// monitor pops and compares whenever the instance drives a valid bit.
module tb_piso_2of4_tx;

    logic       clk;
    logic       rst;
    logic [3:0] din4;
    logic       dinValid4;
    logic       dinReady4;
    logic       sout4;
    logic       soutValid4;
    logic [1:0] phase4;
    logic       busy4;
    logic       done4;

    logic [2:0] din3;
    logic       dinValid3;
    logic       dinReady3;
    logic       sout3;
    logic       soutValid3;
    logic [1:0] phase3;
    logic       busy3;
    logic       done3;

    int testCount = 0;
    int failCount = 0;

    logic queue4[$];
    logic queue3[$];

    piso_2of4_tx #(.N_BIT(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .din        (din4),
        .din_valid  (dinValid4),
        .din_ready  (dinReady4),
        .sout       (sout4),
        .sout_valid (soutValid4),
        .phase      (phase4),
        .busy       (busy4),
        .done       (done4)
    );

    piso_2of4_tx #(.N_BIT(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .din        (din3),
        .din_valid  (dinValid3),
        .din_ready  (dinReady3),
        .sout       (sout3),
        .sout_valid (soutValid3),
        .phase      (phase3),
        .busy       (busy3),
        .done       (done3)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle just after it
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Present a word to the 4-bit instance for one edge and record its bits
    task automatic applyStimulus(input logic [3:0] word);
        din4      = word;
        dinValid4 = 1'b1;
        for (int i = 3; i >= 0; i--) queue4.push_back(word[i]);
        stepCycle();
        dinValid4 = 1'b0;
        din4      = 4'h0;
    endtask

    // Wait, with a bound, for the first valid bit and check how long it took
    task automatic waitFirstBit(input string tag, input int expectedSteps);
        int steps = 0;
        while (!soutValid4 && steps < 12) begin
            stepCycle();
            steps++;
        end
        checkOutput({tag, "_wait"}, steps, expectedSteps);
        checkOutput({tag, "_phase0"}, phase4, 2'd0);
    endtask

    // Check the valid pattern of a 4-bit word over two frames, then the done cycle
    task automatic checkFrames(input string tag);
        logic [5:0] pattern;
        pattern = 6'b110011;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("%s_valid%0d", tag, k), soutValid4, pattern[5-k]);
            stepCycle();
        end
        checkOutput({tag, "_done"}, done4, 1'b1);
        checkOutput({tag, "_busy"}, busy4, 1'b0);
        checkOutput({tag, "_ready"}, dinReady4, 1'b1);
        checkOutput({tag, "_donephase"}, phase4, 2'd2);
    endtask

    // Scoreboard monitor for the 4-bit instance, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (soutValid4) begin
                checkOutput("sb4_nonempty", (queue4.size() > 0), 1'b1);
                if (queue4.size() > 0) checkOutput("sb4_bit", sout4, queue4.pop_front());
            end else if (sout4 !== 1'b0) begin
                checkOutput("sb4_idle_zero", sout4, 1'b0);
            end
        end
    end

    // Scoreboard monitor for the 3-bit instance
    always @(negedge clk) begin
        if (!rst) begin
            if (soutValid3) begin
                checkOutput("sb3_nonempty", (queue3.size() > 0), 1'b1);
                if (queue3.size() > 0) checkOutput("sb3_bit", sout3, queue3.pop_front());
            end else if (sout3 !== 1'b0) begin
                checkOutput("sb3_idle_zero", sout3, 1'b0);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        din4      = 4'h0;
        dinValid4 = 1'b0;
        din3      = 3'h0;
        dinValid3 = 1'b0;

        // Reset held for three cycles
        repeat (3) stepCycle();
        checkOutput("rst_phase", phase4, 2'd0);
        checkOutput("rst_ready", dinReady4, 1'b1);
        checkOutput("rst_sout", sout4, 1'b0);
        checkOutput("rst_valid", soutValid4, 1'b0);
        checkOutput("rst_busy", busy4, 1'b0);
        checkOutput("rst_done", done4, 1'b0);
        rst = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            stepCycle();
            checkOutput($sformatf("phase_count%0d", p), phase4, p % 4);
        end

        // Word loaded on a phase-0 edge
        applyStimulus(4'b1011);
        checkOutput("t2_armed_busy", busy4, 1'b1);
        checkOutput("t2_armed_ready", dinReady4, 1'b0);
        waitFirstBit("t2", 3);
        checkFrames("t2");

        // Back-to-back word accepted in the done cycle
        applyStimulus(4'b1100);
        checkOutput("t4_done_cleared", done4, 1'b0);
        waitFirstBit("t4", 1);
        checkFrames("t4");

        // Word loaded on a phase-3 edge waits a full frame
        stepCycle();
        checkOutput("t3_phase3", phase4, 2'd3);
        applyStimulus(4'b0111);
        waitFirstBit("t3", 4);
        checkFrames("t3");

        // Reset during SEND after the first bit
        stepCycle();
        stepCycle();
        applyStimulus(4'b1001);
        waitFirstBit("t5", 3);
        rst = 1'b1;
        stepCycle();
        queue4.delete();
        checkOutput("t5_rst_phase", phase4, 2'd0);
        checkOutput("t5_rst_busy", busy4, 1'b0);
        checkOutput("t5_rst_ready", dinReady4, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            checkOutput($sformatf("t5_nodone%0d", k), done4, 1'b0);
        end
        applyStimulus(4'b0110);
        waitFirstBit("t5b", 3);
        checkFrames("t5b");

        // Odd width: 3'b101 on the 3-bit instance
        stepCycle();
        stepCycle();
        checkOutput("t6_start_phase", phase3, 2'd0);
        din3      = 3'b101;
        dinValid3 = 1'b1;
        for (int i = 2; i >= 0; i--) queue3.push_back(din3[i]);
        stepCycle();
        dinValid3 = 1'b0;
        din3      = 3'h0;
        checkOutput("t6_armed_busy", busy3, 1'b1);
        repeat (3) stepCycle();
        begin
            logic [4:0] pattern3;
            pattern3 = 5'b11001;
            for (int k = 0; k < 5; k++) begin
                checkOutput($sformatf("t6_valid%0d", k), soutValid3, pattern3[4-k]);
                stepCycle();
            end
        end
        checkOutput("t6_tail_valid", soutValid3, 1'b0);
        checkOutput("t6_tail_phase", phase3, 2'd1);
        checkOutput("t6_done", done3, 1'b1);
        checkOutput("t6_busy", busy3, 1'b0);
        stepCycle();
        checkOutput("t6_done_pulse", done3, 1'b0);

        // Every expected bit must have been consumed
        stepCycle();
        checkOutput("sb4_drained", queue4.size(), 0);
        checkOutput("sb3_drained", queue3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
